// File: rtl/multicycle_control_if.sv
// ============================================================================
// Module      : multicycle_control_if
// Description : Instruction/memory-side bus between the multi-cycle MIPS
//               controller and its IR, memory port and datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] function_code;
    logic [4:0] b_code;
    logic       pc_is_zero;
    logic       mem_waitrequest;
    logic [2:0] state;
    logic       active;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write_enable;
    logic       multdiv_start;
    logic       hi_wren;
    logic       lo_wren;
    logic       multdiv_busy;
    logic       stall;

    modport slave (
        input  opcode, function_code, b_code, pc_is_zero, mem_waitrequest,
        output state, active, mem_read, mem_write, iord, ir_write, pc_write,
               reg_write_enable, multdiv_start, hi_wren, lo_wren, multdiv_busy, stall
    );

    modport master (
        output opcode, function_code, b_code, pc_is_zero, mem_waitrequest,
        input  state, active, mem_read, mem_write, iord, ir_write, pc_write,
               reg_write_enable, multdiv_start, hi_wren, lo_wren, multdiv_busy, stall
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle MIPS controller (FETCH/DECODE/EXEC/MEM/WB/HALT)
//               with background mult/div latency counter.
//               Optional macro HILO_INTERLOCK_EN stalls HI/LO ops while busy.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    multicycle_control_if.slave   bus
);

    localparam int c_CNT_W = $clog2(DIV_LATENCY + 1);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_LATENCY);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_LATENCY);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_rtype, w_is_mult, w_is_div, w_is_mthi, w_is_mtlo;
    logic       w_is_jump, w_is_load, w_is_store, w_reg_write;
    logic       w_hold, w_busy, w_start, w_done;

    assign w_op = bus.opcode;
    assign w_fn = bus.function_code;

    assign w_rtype    = (w_op == 6'd0);
    assign w_is_mult  = w_rtype && (w_fn == 6'd24 || w_fn == 6'd25);
    assign w_is_div   = w_rtype && (w_fn == 6'd26 || w_fn == 6'd27);
    assign w_is_mthi  = w_rtype && (w_fn == 6'd17);
    assign w_is_mtlo  = w_rtype && (w_fn == 6'd19);
    assign w_is_jump  = (w_op == 6'd2) || (w_op == 6'd3) ||
                        (w_rtype && (w_fn == 6'd8 || w_fn == 6'd9));
    assign w_is_load  = (w_op >= 6'd32) && (w_op <= 6'd38);
    assign w_is_store = (w_op == 6'd40) || (w_op == 6'd41) || (w_op == 6'd43);
    assign w_reg_write = (w_rtype && (w_fn != 6'd8) && !(w_fn >= 6'd24 && w_fn <= 6'd27)) ||
                         (w_op == 6'd3) || (w_op >= 6'd9 && w_op <= 6'd15) ||
                         (w_op == 6'd1 && (bus.b_code == 5'd16 || bus.b_code == 5'd17));

    assign w_busy = (r_count != '0);

`ifdef HILO_INTERLOCK_EN
    logic w_hilo_op;
    assign w_hilo_op = w_is_mult || w_is_div || w_is_mthi || w_is_mtlo ||
                       (w_rtype && (w_fn == 6'd16 || w_fn == 6'd18));
    assign w_hold    = (r_state == c_EXEC) && w_hilo_op && w_busy;
`else
    assign w_hold    = 1'b0;
`endif

    assign w_start = !reset && (r_state == c_EXEC) && !w_hold && (w_is_mult || w_is_div);
    // A reload on the completion cycle drops the old result, so no write.
    assign w_done  = !reset && (r_count == c_ONE) && !w_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= w_is_div ? c_DIV_LOAD : c_MULT_LOAD;
        end else if (w_busy) begin
            r_count <= r_count - c_ONE;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_FETCH: begin
                if (bus.pc_is_zero)             w_next_state = c_HALT;
                else if (!bus.mem_waitrequest)  w_next_state = c_DECODE;
            end
            c_DECODE: w_next_state = c_EXEC;
            c_EXEC: begin
                if (w_hold)                               w_next_state = c_EXEC;
                else if (w_is_load || w_is_store)         w_next_state = c_MEM;
                else if (w_is_mthi || w_is_mtlo)          w_next_state = c_FETCH;
                else if (w_is_mult || w_is_div)           w_next_state = c_FETCH;
                else if (w_reg_write)                     w_next_state = c_WB;
                else                                      w_next_state = c_FETCH;
            end
            c_MEM: begin
                if (!bus.mem_waitrequest) w_next_state = w_is_load ? c_WB : c_FETCH;
            end
            c_WB:    w_next_state = c_FETCH;
            c_HALT:  w_next_state = c_HALT;
            default: w_next_state = c_FETCH;
        endcase
    end

    // Strobes are forced low while reset is held so the reset cycle is quiet.
    always_comb begin
        bus.mem_read         = 1'b0;
        bus.mem_write        = 1'b0;
        bus.iord             = 1'b0;
        bus.ir_write         = 1'b0;
        bus.pc_write         = 1'b0;
        bus.reg_write_enable = 1'b0;
        bus.hi_wren          = 1'b0;
        bus.lo_wren          = 1'b0;
        if (!reset) begin
            case (r_state)
                c_FETCH: begin
                    if (!bus.pc_is_zero) begin
                        bus.mem_read = 1'b1;
                        bus.ir_write = !bus.mem_waitrequest;
                        bus.pc_write = !bus.mem_waitrequest;
                    end
                end
                c_EXEC: begin
                    // Conditional-branch PC update is qualified in the datapath.
                    if (!w_hold) begin
                        bus.pc_write = w_is_jump;
                        bus.hi_wren  = w_is_mthi;
                        bus.lo_wren  = w_is_mtlo;
                    end
                end
                c_MEM: begin
                    bus.mem_read  = w_is_load;
                    bus.mem_write = w_is_store;
                    bus.iord      = 1'b1;
                end
                c_WB:    bus.reg_write_enable = 1'b1;
                default: ;
            endcase
            if (w_done && r_state != c_HALT) begin
                bus.hi_wren = 1'b1;
                bus.lo_wren = 1'b1;
            end
        end
    end

    assign bus.state         = r_state;
    assign bus.active        = (r_state != c_HALT);
    assign bus.multdiv_start = w_start;
    assign bus.multdiv_busy  = w_busy;
    assign bus.stall         = !reset && w_hold;

endmodule

`default_nettype wire
